hazard_stall_controller: RTL

//  Pipeline sequencing controller for the 5-stage ARM core. Detects load-use hazards that
//  the EXE/MEM forwarding network cannot resolve. Freezes the pipeline during multi-cycle

---
 rtl/hazard_stall_controller_if.sv | 49 ++++
 rtl/hazard_stall_controller.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-control bundle between the 5-stage core datapath and the hazard/stall controller.
//   Hazard inputs (datapath -> controller):
//     Rn_ID, Rm_ID, useRn_ID, useRm_ID      source operands of the ID instruction
//     Aw_EXE, RegWrite_EXE, MemRead_EXE     destination/type of the EXE instruction
//     branch_taken_EXE                      taken branch resolved in EXE
//     mem_req_MEM, mem_ready                data-memory access handshake in MEM
//   Control outputs (controller -> datapath):
//     pc_write, ifid_write, idex_write, exmem_write, memwb_write   register enables
//     ifid_flush, idex_bubble                                     NOP insertion
//     state, stall_cnt                                            status / perf counter
// Modport master is the datapath side; modport slave is the controller side.
interface hazard_stall_controller_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       Rn_ID;
  logic [4:0]       Rm_ID;
  logic             useRn_ID;
  logic             useRm_ID;
  logic [4:0]       Aw_EXE;
  logic             RegWrite_EXE;
  logic             MemRead_EXE;
  logic             branch_taken_EXE;
  logic             mem_req_MEM;
  logic             mem_ready;

  logic             pc_write;
  logic             ifid_write;
  logic             idex_write;
  logic             exmem_write;
  logic             memwb_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output Rn_ID, Rm_ID, useRn_ID, useRm_ID, Aw_EXE, RegWrite_EXE, MemRead_EXE,
           branch_taken_EXE, mem_req_MEM, mem_ready,
    input  pc_write, ifid_write, idex_write, exmem_write, memwb_write, ifid_flush,
           idex_bubble, state, stall_cnt
  );

  modport slave (
    input  Rn_ID, Rm_ID, useRn_ID, useRm_ID, Aw_EXE, RegWrite_EXE, MemRead_EXE,
           branch_taken_EXE, mem_req_MEM, mem_ready,
    output pc_write, ifid_write, idex_write, exmem_write, memwb_write, ifid_flush,
           idex_bubble, state, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the 5-stage core.
//   - Inserts one bubble for load-use hazards forwarding cannot cover.
//   - Freezes the whole pipeline while a data-memory access is outstanding.
//   - Flushes wrong-path instructions for FLUSH_CYCLES cycles after a taken branch.
//   - Counts cycles with pc_write=0 in a saturating counter.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous reset, active low
//   bus      hazard_stall_controller_if.slave (hazard inputs, enables, state, stall_cnt)
// Outputs are a combinational decode of state and inputs; state and counters are registered.
module hazard_stall_controller #(
  parameter int unsigned FLUSH_CYCLES = 1,   // 1..15
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned ZERO_REG     = 31
) (
  input logic                      clk,
  input logic                      reset_n,
  hazard_stall_controller_if.slave bus
);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StMemWait = 2'b01,
    StFlush   = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic memstall;
  logic load_use;

  logic pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic ifid_flush, idex_bubble;

  assign memstall = bus.mem_req_MEM & ~bus.mem_ready;

  // The zero register never carries a real value, so a load into it cannot create a hazard.
  assign load_use = bus.MemRead_EXE & bus.RegWrite_EXE & (bus.Aw_EXE != 5'(ZERO_REG)) &
                    ((bus.useRn_ID & (bus.Aw_EXE == bus.Rn_ID)) |
                     (bus.useRm_ID & (bus.Aw_EXE == bus.Rm_ID)));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;

    unique case (state_q)
      // MEM_WAIT on its ready cycle decodes exactly like RUN.
      StRun, StMemWait: begin
        if (memstall) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_write = 1'b0;
          memwb_write = 1'b0;
          state_d     = StMemWait;
        end else if (bus.branch_taken_EXE) begin
          // Branch beats load-use: the dependent ID instruction is being discarded anyway.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            flush_cnt_d = 4'(FLUSH_CYCLES - 1);
            state_d     = StFlush;
          end else begin
            state_d     = StRun;
          end
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          state_d     = StRun;
        end else begin
          state_d     = StRun;
        end
      end

      StFlush: begin
        if (memstall) begin
          // Freeze in place; the flush resumes where it left off.
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_write = 1'b0;
          memwb_write = 1'b0;
        end else begin
          // Any branch seen here is on the wrong path and is ignored.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (flush_cnt_q <= 4'd1) begin
            flush_cnt_d = 4'd0;
            state_d     = StRun;
          end else begin
            flush_cnt_d = flush_cnt_q - 4'd1;
          end
        end
      end

      default: begin
        state_d     = StRun;
        flush_cnt_d = 4'd0;
      end
    endcase

    // Reset overrides every decode so nothing enters the pipeline during reset.
    if (!reset_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StRun;
      flush_cnt_q <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.idex_write  = idex_write;
  assign bus.exmem_write = exmem_write;
  assign bus.memwb_write = memwb_write;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.state       = state_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule
